// File: rtl/debounce_repeat.sv
// Push-button conditioner: 2-flop synchronizer, counted debounce, press/release
// strobes and a hold-to-auto-repeat strobe for one active-low key.
//
// state  | meaning
// IDLE   | no repeat activity; waiting for an accepted press with repeat enabled
// HOLD   | key held; timing the initial delay before the first repeat strobe
// REPEAT | key held past the initial delay; strobing once per repeat period
module debounce_repeat #(
    parameter int DEB_CYCLES    = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    input  logic i_rep_en,
    output logic o_debounced,
    output logic o_neg,
    output logic o_pos,
    output logic o_rep,
    output logic o_press
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = $clog2(RC_MAX + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RC_W-1:0]  RD_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0]  RP_LAST  = RC_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic             deb;
    logic [DEB_W-1:0] deb_cnt;
    logic [RC_W-1:0]  rc;
    logic             neg;
    logic             pos;
    logic             rep;

    logic accept;
    logic press_acc;
    logic rel_acc;

    // A level change is accepted on the edge that completes DEB_CYCLES of disagreement.
    assign accept    = (s2 != deb) && (deb_cnt == DEB_LAST);
    assign press_acc = accept && !s2;
    assign rel_acc   = accept && s2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            deb     <= 1'b1;
            deb_cnt <= '0;
            rc      <= '0;
            state   <= IDLE;
            neg     <= 1'b0;
            pos     <= 1'b0;
            rep     <= 1'b0;
        end else begin
            s1  <= i_in;
            s2  <= s1;
            neg <= press_acc;
            pos <= rel_acc;
            rep <= 1'b0;

            if (s2 == deb) begin
                deb_cnt <= '0;
            end else if (accept) begin
                deb     <= s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            // Release or repeat-disable takes priority over a coincident terminal count.
            case (state)
                IDLE: begin
                    rc <= '0;
                    if (press_acc && i_rep_en) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (rel_acc || !i_rep_en) begin
                        state <= IDLE;
                        rc    <= '0;
                    end else if (rc == RD_LAST) begin
                        rep   <= 1'b1;
                        state <= REPEAT;
                        rc    <= '0;
                    end else begin
                        rc <= rc + 1'b1;
                    end
                end
                REPEAT: begin
                    if (rel_acc || !i_rep_en) begin
                        state <= IDLE;
                        rc    <= '0;
                    end else if (rc == RP_LAST) begin
                        rep <= 1'b1;
                        rc  <= '0;
                    end else begin
                        rc <= rc + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rc    <= '0;
                end
            endcase
        end
    end

    assign o_debounced = deb;
    assign o_neg       = neg;
    assign o_pos       = pos;
    assign o_rep       = rep;
    assign o_press     = neg | rep;

endmodule

// File: tb/tb_debounce_repeat.sv
// Bench for debounce_repeat: expected strobe events are scheduled into a queue
// when key stimulus is applied and matched cycle-by-cycle against the outputs.
module tb_debounce_repeat;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = DEB + 2;

    localparam logic [2:0] EV_NEG = 3'b100;
    localparam logic [2:0] EV_POS = 3'b010;
    localparam logic [2:0] EV_REP = 3'b001;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_in;
    logic i_rep_en;
    logic o_debounced;
    logic o_neg;
    logic o_pos;
    logic o_rep;
    logic o_press;

    debounce_repeat #(
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_in       (i_in),
        .i_rep_en   (i_rep_en),
        .o_debounced(o_debounced),
        .o_neg      (o_neg),
        .o_pos      (o_pos),
        .o_rep      (o_rep),
        .o_press    (o_press)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] code;
    } ev_t;

    ev_t sbq[$];
    int  total  = 0;
    int  bad    = 0;
    bit  mon_en = 1'b0;

    // Every cycle: strobes must equal the scheduled event for that cycle, else all zero.
    always @(negedge i_clk) begin
        logic [2:0] exp_code;
        logic [3:0] obs;
        logic [3:0] exp_v;
        if (mon_en) begin
            exp_code = 3'b000;
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missed_event cyc=%0d actual=none required_code=%b", sbq[0].cyc, sbq[0].code);
                sbq.delete(0);
            end
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                exp_code = sbq[0].code;
                sbq.delete(0);
            end
            obs   = {o_neg, o_pos, o_rep, o_press};
            exp_v = {exp_code, exp_code[2] | exp_code[0]};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL strobes cyc=%0d actual{neg,pos,rep,press}=%b required=%b", cyc, obs, exp_v);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic push_ev(input int c, input logic [2:0] code);
        ev_t e;
        e.cyc  = c;
        e.code = code;
        sbq.push_back(e);
    endtask

    // Key goes low right after edge t_press and high right after edge t_rel.
    task automatic push_press(input int t_press, input int t_rel, input bit rep_on);
        int t_pos;
        int r;
        t_pos = t_rel + LAT;
        push_ev(t_press + LAT, EV_NEG);
        if (rep_on) begin
            r = t_press + LAT + RD;
            while (r < t_pos) begin
                push_ev(r, EV_REP);
                r += RP;
            end
        end
        push_ev(t_pos, EV_POS);
    endtask

    task automatic test_reset;
        int t0;
        i_rst_n  = 1'b0;
        i_in     = 1'b0;
        i_rep_en = 1'b1;
        tick(1);
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (o_debounced !== 1'b1) begin
                bad++;
                $display("FAIL reset_level actual=%b required=1", o_debounced);
            end
            if (i < 2) tick(1);
        end
        i_rst_n = 1'b1;
        t0 = cyc;
        push_press(t0, t0 + 10, 1'b1);
        tick(LAT - 1);
        total++;
        if (o_debounced !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_accept actual=%b required=1", o_debounced);
        end
        tick(1);
        total++;
        if (o_debounced !== 1'b0) begin
            bad++;
            $display("FAIL reset_accept_level actual=%b required=0", o_debounced);
        end
        tick(4);
        i_in = 1'b1;
        tick(20);
        total++;
        if (o_debounced !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_level actual=%b required=1", o_debounced);
        end
    endtask

    task automatic test_bounce;
        i_in = 1'b0;
        tick(3);
        i_in = 1'b1;
        tick(1);
        i_in = 1'b0;
        tick(2);
        i_in = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            total++;
            if (o_debounced !== 1'b1) begin
                bad++;
                $display("FAIL bounce_level actual=%b required=1", o_debounced);
            end
        end
    endtask

    task automatic test_clean_press;
        int t0;
        t0   = cyc;
        i_in = 1'b0;
        push_press(t0, t0 + 52, 1'b1);
        tick(30);
        total++;
        if (o_debounced !== 1'b0) begin
            bad++;
            $display("FAIL clean_held_level actual=%b required=0", o_debounced);
        end
        tick(22);
        i_in = 1'b1;
        tick(25);
        total++;
        if (o_debounced !== 1'b1) begin
            bad++;
            $display("FAIL clean_release_level actual=%b required=1", o_debounced);
        end
    endtask

    task automatic test_release_on_repeat;
        int t0;
        t0   = cyc;
        i_in = 1'b0;
        push_press(t0, t0 + 30, 1'b1);
        tick(30);
        i_in = 1'b1;
        tick(LAT);
        total++;
        if ({o_pos, o_rep} !== 2'b10) begin
            bad++;
            $display("FAIL collide actual{pos,rep}=%b required=10", {o_pos, o_rep});
        end
        tick(30);
    endtask

    task automatic test_rep_disabled;
        int t0;
        i_rep_en = 1'b0;
        t0       = cyc;
        i_in     = 1'b0;
        push_press(t0, t0 + 100, 1'b0);
        tick(100);
        i_in = 1'b1;
        tick(20);

        t0   = cyc;
        i_in = 1'b0;
        push_press(t0, t0 + 60, 1'b0);
        tick(30);
        i_rep_en = 1'b1;
        tick(30);
        i_in = 1'b1;
        tick(20);

        t0   = cyc;
        i_in = 1'b0;
        push_press(t0, t0 + 60, 1'b0);
        tick(15);
        i_rep_en = 1'b0;
        tick(5);
        i_rep_en = 1'b1;
        tick(40);
        i_in = 1'b1;
        tick(20);
    endtask

    task automatic test_reset_mid_repeat;
        int t0;
        int d;
        i_rep_en = 1'b1;
        t0       = cyc;
        i_in     = 1'b0;
        push_ev(t0 + LAT, EV_NEG);
        push_ev(t0 + LAT + RD, EV_REP);
        push_ev(t0 + LAT + RD + RP, EV_REP);
        tick(33);
        i_rst_n = 1'b0;
        tick(1);
        total++;
        if (o_debounced !== 1'b1) begin
            bad++;
            $display("FAIL midreset_level actual=%b required=1", o_debounced);
        end
        i_rst_n = 1'b1;
        d = cyc;
        push_press(d, d + 30, 1'b1);
        tick(30);
        i_in = 1'b1;
        tick(20);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_release_on_repeat();
        test_rep_disabled();
        test_reset_mid_repeat();
        mon_en = 1'b0;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL leftover_events actual=%0d required=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
